cu_mc: RTL and testbench
========================

# cu_mc

Multi-cycle, parametrised control unit for the mycpu datapath. It supersedes the single-cycle decoder. It generalises the register-field width and adds a request/ready handshake for instruction fetch, memory and IO accesses. It also adds a resumable halt state. It sits between the instruction register and the datapath/memory/IO control inputs and drives every datapath control line.

## Interface
- RA_W, 3: register-address field width; instruction width is 7+3*RA_W.
- MEM_HS, 1: 1 = fetch, LD, ST, IOR and IOW wait for rdy_in; 0 = rdy_in ignored and treated as 1, giving single-cycle behaviour.
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ins_in  in  7+3*RA_W  instruction register contents, {opcode[6:0], DR, SA, SB}
- z_in, n_in  in  1 each  ALU zero / negative flags
- rdy_in  in  1  memory/IO access complete this cycle
- go_in  in  1  resume from halt
- req_out  out  1  memory/IO access request
- hlt_out  out  1  core halted
- il_out  out  1  instruction load
- ps_out  out  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump
- rw_out  out  1  register-file write
- rs_out  out  3*(RA_W+1)  {0,DR,0,SA,0,SB}
- mm_out  out  1  memory-address mux select
- md_out  out  2  writeback mux: 00 function unit, 01 constant, 10 IO
- mb_out  out  1  B mux: 1 = constant
- fs_out  out  4  function select
- wen_out  out  1  memory write enable, active-low
- iom_out  out  1  IO space select

## Operation
- States: RST, INF, EX0, HLT.
- Idle output set: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0, wen=1, iom=0, req=0, hlt=0.
- RST: outputs take the idle set; next state is INF unconditionally.
- INF: req=1. If rdy_in=1, il=1 and next state is EX0. If rdy_in=0, il=0 and the state stays INF. All other outputs are idle.
- EX0 decode uses opcode_t values from mycpu_pkg:
  - ps: BRZ gives 10 if z_in else 01; BRN gives 10 if n_in else 01; JMP gives 11; HAL and XXL give 00; all other opcodes give 01.
  - rw=1 except for ST, BRZ, BRN, JMP, IOW, HAL and XXL.
  - md: LDI gives 01, IOR gives 10, otherwise 00.
  - mb=1 for LDI and ADI.
  - fs = opcode[3:0], except BRN gives 0000.
  - wen=0 for ST and IOW.
  - iom=1 for IOR and IOW.
  - rs is the field concatenation; mm=0.
- Access opcodes are LD, ST, IOR and IOW. For these, req=1 in EX0.
  - While rdy_in=0, the state stays EX0. Decoded rs, md, mb, fs and iom are held, but ps=00, rw=0 and wen=1, so nothing commits.
  - The cycle with rdy_in=1 drives the full decode and exits.
- EX0 exit: HAL goes to HLT, all others go to INF.
- HLT: hlt=1 and all other outputs are idle.
  - When go_in=1: ps=01 (skips HAL) and next state is INF.
  - When go_in=0: the state stays HLT.
- With MEM_HS=0, every access completes in its first cycle.

## Timing
- Reset is asynchronous to RST and the outputs are idle immediately. Reset asserted mid-access drops req combinationally. First INF occurs 1 cycle after rst_n release.
- Outputs are combinational from the state, ins_in, the flags, rdy_in and go_in. The only registered element is the state.
- ALU instruction latency: 2 cycles (INF, EX0). Access instruction latency: 2 + fetch waits + access waits.
- rdy_in is sampled only while req=1. A rdy_in pulse outside a request is ignored.
- ins_in must be stable throughout EX0, including wait cycles. The IR is loaded only by il.
- go_in outside HLT is ignored. go_in in the same cycle HLT is entered is also ignored.

## Structure
- In mycpu_pkg, extend cu_state_t with HLT. opcode_t is reused unchanged.
- Add a function or localparam in mycpu_pkg for instruction width 7+3*RA_W.
- Natural sub-module: cu_dec, a purely combinational EX0 decoder with a stall input, instantiated once. The FSM lives in cu_mc.

## Test plan
- Reset: assert rst_n=0 mid-EX0 of ST -> outputs idle and wen=1 immediately. One cycle after release -> INF with req=1.
- Fetch wait, MEM_HS=1: rdy_in=0 for 3 cycles -> il=0 and the state stays INF. Fourth cycle with rdy_in=1 -> il=1, then EX0.
- ST R1,R2, RA_W=3, rdy_in=0 for 2 cycles then 1 -> req=1 throughout. wen=1 and ps=00 during the waits. Final cycle: wen=0, ps=01, rs=12'b0000_0001_0010.
- BRZ with z_in=1 -> ps=10, rw=0. BRN with n_in=0 -> ps=01, fs=0000.
- HAL -> ps=00 and the state enters HLT with hlt=1. Idle until go_in=1, then ps=01 for one cycle and INF follows.
- RA_W=4, MEM_HS=0: ADD DR=9, SA=3, SB=15 -> rs=15'b01001_00011_01111, rw=1, completes in 2 cycles while rdy_in is tied to 0.

Source files
------------

// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types for the mycpu control path.
//   opcode_t    - 7-bit instruction opcodes (low nibble doubles as the ALU
//                 function select for most instructions)
//   cu_state_t  - control-unit sequencer states
//   instr_w()   - instruction width for a given register-field width
//   PS_* / MD_* - PC-select and writeback-mux encodings
package mycpu_pkg;

  typedef enum logic [6:0] {
    MOVA = 7'h00,
    INC  = 7'h01,
    ADD  = 7'h02,
    SUB  = 7'h05,
    DEC  = 7'h06,
    AND  = 7'h08,
    OR   = 7'h09,
    XOR  = 7'h0A,
    NOT  = 7'h0B,
    MOVB = 7'h0C,
    SHR  = 7'h0D,
    SHL  = 7'h0E,
    LD   = 7'h10,
    IOR  = 7'h18,
    ST   = 7'h20,
    IOW  = 7'h28,
    ADI  = 7'h42,
    LDI  = 7'h4C,
    BRZ  = 7'h60,
    BRN  = 7'h61,
    JMP  = 7'h70,
    XXL  = 7'h7E,
    HAL  = 7'h7F
  } opcode_t;

  typedef enum logic [1:0] {
    RST = 2'b00,
    INF = 2'b01,
    EX0 = 2'b10,
    HLT = 2'b11
  } cu_state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_FU = 2'b00;
  localparam logic [1:0] MD_K  = 2'b01;
  localparam logic [1:0] MD_IO = 2'b10;

  function automatic int unsigned instr_w(input int unsigned ra_w);
    return 7 + 3 * ra_w;
  endfunction

endpackage

// File: rtl/cu_dec.sv
// cu_dec: combinational EX0 instruction decoder.
//   ins_in    {opcode, DR, SA, SB}
//   z_in/n_in ALU flags for conditional branches
//   stall_in  access still waiting: suppress every committing control
//   ps/rw/rs/md/mb/fs/wen/iom  decoded datapath controls
//   acc_out   opcode is a memory/IO access (LD, ST, IOR, IOW)
//   hal_out   opcode is HAL
module cu_dec
  import mycpu_pkg::*;
#(
  parameter int unsigned RA_W = 3
) (
  input  logic [instr_w(RA_W)-1:0] ins_in,
  input  logic                     z_in,
  input  logic                     n_in,
  input  logic                     stall_in,
  output logic [1:0]               ps_out,
  output logic                     rw_out,
  output logic [3*(RA_W+1)-1:0]    rs_out,
  output logic [1:0]               md_out,
  output logic                     mb_out,
  output logic [3:0]               fs_out,
  output logic                     wen_out,
  output logic                     iom_out,
  output logic                     acc_out,
  output logic                     hal_out
);

  logic [6:0]      op;
  logic [RA_W-1:0] dr, sa, sb;

  assign op = ins_in[instr_w(RA_W)-1 -: 7];
  assign dr = ins_in[3*RA_W-1 -: RA_W];
  assign sa = ins_in[2*RA_W-1 -: RA_W];
  assign sb = ins_in[RA_W-1:0];

  always_comb begin
    acc_out = op inside {LD, ST, IOR, IOW};
    hal_out = (op == HAL);
    rs_out  = {1'b0, dr, 1'b0, sa, 1'b0, sb};

    case (op)
      BRZ:      ps_out = z_in ? PS_BR : PS_INC;
      BRN:      ps_out = n_in ? PS_BR : PS_INC;
      JMP:      ps_out = PS_JMP;
      HAL, XXL: ps_out = PS_HOLD;
      default:  ps_out = PS_INC;
    endcase

    rw_out  = !(op inside {ST, BRZ, BRN, JMP, IOW, HAL, XXL});
    md_out  = (op == LDI) ? MD_K : (op == IOR) ? MD_IO : MD_FU;
    mb_out  = op inside {LDI, ADI};
    fs_out  = (op == BRN) ? 4'b0000 : op[3:0];
    wen_out = !(op inside {ST, IOW});
    iom_out = op inside {IOR, IOW};

    // Waiting access: operand/mux selects stay decoded, commits are masked.
    if (stall_in) begin
      ps_out  = PS_HOLD;
      rw_out  = 1'b0;
      wen_out = 1'b1;
    end
  end

endmodule

// File: rtl/cu_mc.sv
// cu_mc: multi-cycle control unit for the mycpu datapath.
//   RA_W   register-field width (instruction is 7+3*RA_W bits)
//   MEM_HS 1: fetch and accesses wait for rdy_in; 0: rdy_in treated as 1
//   Inputs : clk, rst_n (async, active-low), ins_in, z_in, n_in,
//            rdy_in (access complete), go_in (resume from halt)
//   Outputs: req_out, hlt_out, il_out, ps_out, rw_out, rs_out, mm_out,
//            md_out, mb_out, fs_out, wen_out (active-low), iom_out
// Only the sequencer state is registered; all outputs are combinational.
module cu_mc
  import mycpu_pkg::*;
#(
  parameter int unsigned RA_W   = 3,
  parameter bit          MEM_HS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [instr_w(RA_W)-1:0] ins_in,
  input  logic                     z_in,
  input  logic                     n_in,
  input  logic                     rdy_in,
  input  logic                     go_in,
  output logic                     req_out,
  output logic                     hlt_out,
  output logic                     il_out,
  output logic [1:0]               ps_out,
  output logic                     rw_out,
  output logic [3*(RA_W+1)-1:0]    rs_out,
  output logic                     mm_out,
  output logic [1:0]               md_out,
  output logic                     mb_out,
  output logic [3:0]               fs_out,
  output logic                     wen_out,
  output logic                     iom_out
);

  cu_state_t state_q, state_d;

  logic                  rdy;
  logic                  stall;
  logic [1:0]            dec_ps;
  logic                  dec_rw;
  logic [3*(RA_W+1)-1:0] dec_rs;
  logic [1:0]            dec_md;
  logic                  dec_mb;
  logic [3:0]            dec_fs;
  logic                  dec_wen;
  logic                  dec_iom;
  logic                  dec_acc;
  logic                  dec_hal;

  assign rdy   = MEM_HS ? rdy_in : 1'b1;
  assign stall = dec_acc & ~rdy;

  cu_dec #(.RA_W(RA_W)) u_dec (
    .ins_in   (ins_in),
    .z_in     (z_in),
    .n_in     (n_in),
    .stall_in (stall),
    .ps_out   (dec_ps),
    .rw_out   (dec_rw),
    .rs_out   (dec_rs),
    .md_out   (dec_md),
    .mb_out   (dec_mb),
    .fs_out   (dec_fs),
    .wen_out  (dec_wen),
    .iom_out  (dec_iom),
    .acc_out  (dec_acc),
    .hal_out  (dec_hal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_out = 1'b0;
    hlt_out = 1'b0;
    il_out  = 1'b0;
    ps_out  = PS_HOLD;
    rw_out  = 1'b0;
    rs_out  = '0;
    mm_out  = 1'b0;
    md_out  = MD_FU;
    mb_out  = 1'b0;
    fs_out  = '0;
    wen_out = 1'b1;
    iom_out = 1'b0;

    case (state_q)
      RST: state_d = INF;

      INF: begin
        req_out = 1'b1;
        if (rdy) begin
          il_out  = 1'b1;
          state_d = EX0;
        end
      end

      EX0: begin
        req_out = dec_acc;
        ps_out  = dec_ps;
        rw_out  = dec_rw;
        rs_out  = dec_rs;
        md_out  = dec_md;
        mb_out  = dec_mb;
        fs_out  = dec_fs;
        wen_out = dec_wen;
        iom_out = dec_iom;
        if (!stall) state_d = dec_hal ? HLT : INF;
      end

      HLT: begin
        hlt_out = 1'b1;
        // Resuming advances the PC past the HAL that stopped the core.
        if (go_in) begin
          ps_out  = PS_INC;
          state_d = INF;
        end
      end

      default: state_d = RST;
    endcase
  end

endmodule

// File: tb/tb_cu_mc.sv
module tb_cu_mc;
  import mycpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // DUT A: RA_W=3, handshake enabled
  logic [15:0] ins_a;
  logic        z_a, n_a, rdy_a, go_a;
  logic        req_a, hlt_a, il_a, rw_a, mm_a, mb_a, wen_a, iom_a;
  logic [1:0]  ps_a, md_a;
  logic [11:0] rs_a;
  logic [3:0]  fs_a;
  // DUT B: RA_W=4, handshake disabled, rdy tied low
  logic [18:0] ins_b;
  logic        z_b, n_b, go_b;
  logic        rdy_b;
  logic        req_b, hlt_b, il_b, rw_b, mm_b, mb_b, wen_b, iom_b;
  logic [1:0]  ps_b, md_b;
  logic [14:0] rs_b;
  logic [3:0]  fs_b;

  assign rdy_b = 1'b0;

  cu_mc #(.RA_W(3), .MEM_HS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_a), .z_in(z_a), .n_in(n_a),
    .rdy_in(rdy_a), .go_in(go_a), .req_out(req_a), .hlt_out(hlt_a),
    .il_out(il_a), .ps_out(ps_a), .rw_out(rw_a), .rs_out(rs_a),
    .mm_out(mm_a), .md_out(md_a), .mb_out(mb_a), .fs_out(fs_a),
    .wen_out(wen_a), .iom_out(iom_a)
  );

  cu_mc #(.RA_W(4), .MEM_HS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_b), .z_in(z_b), .n_in(n_b),
    .rdy_in(rdy_b), .go_in(go_b), .req_out(req_b), .hlt_out(hlt_b),
    .il_out(il_b), .ps_out(ps_b), .rw_out(rw_b), .rs_out(rs_b),
    .mm_out(mm_b), .md_out(md_b), .mb_out(mb_b), .fs_out(fs_b),
    .wen_out(wen_b), .iom_out(iom_b)
  );

  typedef struct packed {
    logic       req, hlt, il;
    logic [1:0] ps;
    logic       rw;
    logic [11:0] rs;
    logic       mm;
    logic [1:0] md;
    logic       mb;
    logic [3:0] fs;
    logic       wen, iom;
  } outs_t;

  outs_t act_a;
  assign act_a = {req_a, hlt_a, il_a, ps_a, rw_a, rs_a, mm_a, md_a, mb_a,
                  fs_a, wen_a, iom_a};

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic        z, n, rdy;
    logic [1:0]  ps;
    logic        rw;
    logic [11:0] rs;
    logic [1:0]  md;
    logic        mb;
    logic [3:0]  fs;
    logic        wen, iom, req;
  } vec_t;

  typedef enum {P_RESET, P_FETCH, P_EXEC, P_HALT} phase_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic outs_t idle();
    outs_t e;
    e = '0;
    e.wen = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] mk3(input opcode_t op, input logic [2:0] dr,
                                      input logic [2:0] sa, input logic [2:0] sb);
    return {op, dr, sa, sb};
  endfunction

  task automatic chk(input string name, input outs_t a, input outs_t e);
    vec_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("FAIL %s: got %07h want %07h (req hlt il ps rw rs mm md mb fs wen iom)",
               name, a, e);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] a, input logic [31:0] e);
    vec_cnt++;
    if (a !== e) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", name, a, e);
    end
  endtask

  // Reference: controls derived directly from the instruction-set rules.
  task automatic model(input phase_t ph, input logic [15:0] ins,
                       input logic z, input logic n, input logic rdy, input logic go,
                       output outs_t e, output phase_t nx);
    logic [6:0] op;
    logic       access, done;
    e  = idle();
    nx = ph;
    case (ph)
      P_RESET: nx = P_FETCH;
      P_FETCH: begin
        e.req = 1'b1;
        if (rdy) begin
          e.il = 1'b1;
          nx   = P_EXEC;
        end
      end
      P_EXEC: begin
        op     = ins[15:9];
        access = op inside {LD, ST, IOR, IOW};
        done   = !access || rdy;
        e.req  = access;
        e.rs   = {1'b0, ins[8:6], 1'b0, ins[5:3], 1'b0, ins[2:0]};
        e.md   = (op == LDI) ? 2'd1 : (op == IOR) ? 2'd2 : 2'd0;
        e.mb   = op inside {LDI, ADI};
        e.fs   = (op == BRN) ? 4'd0 : op[3:0];
        e.iom  = op inside {IOR, IOW};
        if (done) begin
          if (op == BRZ)                 e.ps = z ? 2'd2 : 2'd1;
          else if (op == BRN)            e.ps = n ? 2'd2 : 2'd1;
          else if (op == JMP)            e.ps = 2'd3;
          else if (op inside {HAL, XXL}) e.ps = 2'd0;
          else                           e.ps = 2'd1;
          e.rw  = !(op inside {ST, BRZ, BRN, JMP, IOW, HAL, XXL});
          e.wen = !(op inside {ST, IOW});
          nx    = (op == HAL) ? P_HALT : P_FETCH;
        end
      end
      P_HALT: begin
        e.hlt = 1'b1;
        if (go) begin
          e.ps = 2'd1;
          nx   = P_FETCH;
        end
      end
      default: nx = P_RESET;
    endcase
  endtask

  // Leaves both DUTs at a falling edge in their first fetch cycle.
  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    rdy_a = 1'b0; go_a = 1'b0; z_a = 1'b0; n_a = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic to_ex0();
    rdy_a = 1'b1;
    go_a  = 1'b0;
    @(negedge clk);
  endtask

  vec_t    vt[$];
  outs_t   e;
  phase_t  ph, nx;
  opcode_t ops[23];

  initial begin
    rst_n = 1'b0;
    ins_a = '0; z_a = 1'b0; n_a = 1'b0; rdy_a = 1'b0; go_a = 1'b0;
    ins_b = {ADD, 4'd9, 4'd3, 4'd15}; z_b = 1'b0; n_b = 1'b0; go_b = 1'b0;

    vt.push_back('{"add",    mk3(ADD,3'd3,3'd1,3'd2), 1'b0,1'b0,1'b0, 2'b01,1'b1,12'h312, 2'b00,1'b0,4'h2,1'b1,1'b0,1'b0});
    vt.push_back('{"sub",    mk3(SUB,3'd1,3'd2,3'd3), 1'b1,1'b1,1'b1, 2'b01,1'b1,12'h123, 2'b00,1'b0,4'h5,1'b1,1'b0,1'b0});
    vt.push_back('{"ldi",    mk3(LDI,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b01,1'b1,12'h123, 2'b01,1'b1,4'hC,1'b1,1'b0,1'b0});
    vt.push_back('{"adi",    mk3(ADI,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b01,1'b1,12'h123, 2'b00,1'b1,4'h2,1'b1,1'b0,1'b0});
    vt.push_back('{"brz_z1", mk3(BRZ,3'd1,3'd2,3'd3), 1'b1,1'b0,1'b0, 2'b10,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b0});
    vt.push_back('{"brz_z0", mk3(BRZ,3'd1,3'd2,3'd3), 1'b0,1'b1,1'b0, 2'b01,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b0});
    vt.push_back('{"brn_n0", mk3(BRN,3'd1,3'd2,3'd3), 1'b1,1'b0,1'b0, 2'b01,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b0});
    vt.push_back('{"brn_n1", mk3(BRN,3'd1,3'd2,3'd3), 1'b0,1'b1,1'b0, 2'b10,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b0});
    vt.push_back('{"jmp",    mk3(JMP,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b11,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b0});
    vt.push_back('{"ld_rdy", mk3(LD, 3'd1,3'd2,3'd3), 1'b0,1'b0,1'b1, 2'b01,1'b1,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b1});
    vt.push_back('{"ld_wait",mk3(LD, 3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b00,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b1,1'b0,1'b1});
    vt.push_back('{"st_rdy", mk3(ST, 3'd1,3'd2,3'd3), 1'b0,1'b0,1'b1, 2'b01,1'b0,12'h123, 2'b00,1'b0,4'h0,1'b0,1'b0,1'b1});
    vt.push_back('{"ior_rdy",mk3(IOR,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b1, 2'b01,1'b1,12'h123, 2'b10,1'b0,4'h8,1'b1,1'b1,1'b1});
    vt.push_back('{"iow_wt", mk3(IOW,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b00,1'b0,12'h123, 2'b00,1'b0,4'h8,1'b1,1'b1,1'b1});
    vt.push_back('{"iow_rdy",mk3(IOW,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b1, 2'b01,1'b0,12'h123, 2'b00,1'b0,4'h8,1'b0,1'b1,1'b1});
    vt.push_back('{"hal",    mk3(HAL,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b00,1'b0,12'h123, 2'b00,1'b0,4'hF,1'b1,1'b0,1'b0});
    vt.push_back('{"xxl",    mk3(XXL,3'd1,3'd2,3'd3), 1'b0,1'b0,1'b0, 2'b00,1'b0,12'h123, 2'b00,1'b0,4'hE,1'b1,1'b0,1'b0});

    // Reset state while rst_n is held low.
    #3;
    chk("reset_idle", act_a, idle());

    foreach (vt[i]) begin
      reset_all();
      ins_a = vt[i].ins;
      to_ex0();
      z_a = vt[i].z; n_a = vt[i].n; rdy_a = vt[i].rdy;
      #2;
      e = idle();
      e.req = vt[i].req; e.ps = vt[i].ps; e.rw = vt[i].rw; e.rs = vt[i].rs;
      e.md = vt[i].md; e.mb = vt[i].mb; e.fs = vt[i].fs; e.wen = vt[i].wen;
      e.iom = vt[i].iom;
      chk(vt[i].name, act_a, e);
    end

    // Async reset in the middle of a waiting ST R1,R2.
    reset_all();
    ins_a = mk3(ST, 3'd0, 3'd1, 3'd2);
    to_ex0();
    rdy_a = 1'b0;
    #2;
    e = idle(); e.req = 1'b1; e.rs = 12'b0000_0001_0010;
    chk("st_wait_pre_rst", act_a, e);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_access", act_a, idle());
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    e = idle(); e.req = 1'b1;
    chk("inf_after_rst", act_a, e);

    // Fetch waits three cycles, then completes.
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      rdy_a = 1'b0;
      #2;
      e = idle(); e.req = 1'b1;
      chk("fetch_wait", act_a, e);
    end
    @(negedge clk);
    rdy_a = 1'b1;
    #2;
    e = idle(); e.req = 1'b1; e.il = 1'b1;
    chk("fetch_done", act_a, e);

    // ST access waits two cycles, then commits.
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      rdy_a = 1'b0;
      #2;
      e = idle(); e.req = 1'b1; e.rs = 12'b0000_0001_0010;
      chk("st_wait", act_a, e);
    end
    @(negedge clk);
    rdy_a = 1'b1;
    #2;
    e = idle(); e.req = 1'b1; e.rs = 12'b0000_0001_0010; e.ps = 2'b01; e.wen = 1'b0;
    chk("st_commit", act_a, e);
    @(negedge clk);
    rdy_a = 1'b0;
    #2;
    e = idle(); e.req = 1'b1;
    chk("st_back_inf", act_a, e);

    // HAL with go asserted in the entry cycle; rdy pulses while halted.
    reset_all();
    ins_a = mk3(HAL, 3'd0, 3'd0, 3'd0);
    to_ex0();
    go_a = 1'b1;
    #2;
    e = idle(); e.fs = 4'hF;
    chk("hal_ex0", act_a, e);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      go_a = 1'b0; rdy_a = 1'b1;
      #2;
      e = idle(); e.hlt = 1'b1;
      chk("halted", act_a, e);
    end
    @(negedge clk);
    go_a = 1'b1; rdy_a = 1'b0;
    #2;
    e = idle(); e.hlt = 1'b1; e.ps = 2'b01;
    chk("hlt_resume", act_a, e);
    @(negedge clk);
    go_a = 1'b0;
    #2;
    e = idle(); e.req = 1'b1;
    chk("resume_inf", act_a, e);

    // DUT B: no handshake, rdy tied low, ADD DR=9 SA=3 SB=15.
    ins_b = {ADD, 4'd9, 4'd3, 4'd15};
    reset_all();
    #2;
    chk_v("b_fetch", 32'({req_b, il_b, hlt_b}), 32'b110);
    @(negedge clk);
    #2;
    chk_v("b_add_rs", 32'(rs_b), 32'(15'b01001_00011_01111));
    chk_v("b_add_ctl", 32'({rw_b, ps_b, req_b, fs_b}), 32'({1'b1, 2'b01, 1'b0, 4'h2}));
    @(negedge clk);
    ins_b = {ST, 4'd0, 4'd1, 4'd2};
    #2;
    chk_v("b_add_done", 32'({req_b, il_b}), 32'b11);
    @(negedge clk);
    #2;
    chk_v("b_st", 32'({wen_b, ps_b, req_b, rw_b}), 32'({1'b0, 2'b01, 1'b1, 1'b0}));

    // Randomised run against the reference model.
    ops = '{MOVA, INC, ADD, SUB, DEC, AND, OR, XOR, NOT, MOVB, SHR, SHL,
            LD, IOR, ST, IOW, ADI, LDI, BRZ, BRN, JMP, XXL, HAL};
    reset_all();
    ph = P_FETCH;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (ph != P_EXEC) begin
        if ($urandom_range(7) == 0)
          ins_a = 16'($urandom);
        else
          ins_a = {ops[$urandom_range(22)], 9'($urandom)};
      end
      z_a   = 1'($urandom);
      n_a   = 1'($urandom);
      rdy_a = 1'($urandom);
      go_a  = ($urandom_range(3) == 0);
      #2;
      model(ph, ins_a, z_a, n_a, rdy_a, go_a, e, nx);
      chk("random", act_a, e);
      ph = nx;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
